// File: rtl/contador.sv
// Up/down binary counter with terminal-value flags, a registered wrap pulse
// and a registered copy of the direction used in the last update.
module contador #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clkk,
    input  logic             rstt,
    input  logic             udd,
    output logic [WIDTH-1:0] contt,
    output logic             max_o,
    output logic             min_o,
    output logic             wrap_o,
    output logic             dir_o
);

    localparam logic [WIDTH-1:0] MAX_V = '1;
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             dir_q;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (udd) begin
            if (cnt_q == MAX_V) begin
                // At a terminal value saturation holds; otherwise wrap and flag it.
                if (!SATURATE) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + ONE_V;
            end
        end else begin
            if (cnt_q == '0) begin
                if (!SATURATE) begin
                    cnt_d  = MAX_V;
                    wrap_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - ONE_V;
            end
        end
    end

    always_ff @(posedge clkk or negedge rstt) begin
        if (!rstt) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            dir_q  <= udd;
        end
    end

    assign contt  = cnt_q;
    assign max_o  = (cnt_q == MAX_V);
    assign min_o  = (cnt_q == '0);
    assign wrap_o = wrap_q;
    assign dir_o  = dir_q;

endmodule

// File: tb/tb_contador.sv
// Directed bench for contador: a wrapping instance driven from vector tables
// and hand sequences, plus a saturating instance exercised at both limits.
module tb_contador;

    logic       clkk;
    logic       rstt, udd;
    logic [7:0] contt;
    logic       max_o, min_o, wrap_o, dir_o;

    logic       rstt_s, udd_s;
    logic [7:0] contt_s;
    logic       max_s, min_s, wrap_s, dir_s;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        sat_wrap_seen = 1'b0;

    contador #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .clkk(clkk), .rstt(rstt), .udd(udd), .contt(contt),
        .max_o(max_o), .min_o(min_o), .wrap_o(wrap_o), .dir_o(dir_o)
    );

    contador #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clkk(clkk), .rstt(rstt_s), .udd(udd_s), .contt(contt_s),
        .max_o(max_s), .min_o(min_s), .wrap_o(wrap_s), .dir_o(dir_s)
    );

    initial clkk = 1'b0;
    always #5 clkk = ~clkk;

    always @(negedge clkk) if (rstt_s && wrap_s) sat_wrap_seen = 1'b1;

    typedef struct {
        logic       udd;
        logic [7:0] cnt;
        logic       mx, mn, wr, dr;
    } vec_t;

    vec_t tab_a[8];
    vec_t tab_b[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".contt"}, 32'(contt), 32'(v.cnt));
        chk({tag, ".max"},   32'(max_o), 32'(v.mx));
        chk({tag, ".min"},   32'(min_o), 32'(v.mn));
        chk({tag, ".wrap"},  32'(wrap_o), 32'(v.wr));
        chk({tag, ".dir"},   32'(dir_o), 32'(v.dr));
    endtask

    initial begin
        //                udd  cnt   max   min   wrap  dir
        tab_a[0] = '{1'b1, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1};
        tab_a[1] = '{1'b1, 8'd2,   1'b0, 1'b0, 1'b0, 1'b1};
        tab_a[2] = '{1'b0, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0};
        tab_a[3] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
        tab_a[4] = '{1'b0, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0};
        tab_a[5] = '{1'b1, 8'd0,   1'b0, 1'b1, 1'b1, 1'b1};
        tab_a[6] = '{1'b1, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1};
        tab_a[7] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};

        tab_b[0] = '{1'b1, 8'd11,  1'b0, 1'b0, 1'b0, 1'b1};
        tab_b[1] = '{1'b0, 8'd10,  1'b0, 1'b0, 1'b0, 1'b0};
        tab_b[2] = '{1'b1, 8'd11,  1'b0, 1'b0, 1'b0, 1'b1};
        tab_b[3] = '{1'b0, 8'd10,  1'b0, 1'b0, 1'b0, 1'b0};
        tab_b[4] = '{1'b1, 8'd11,  1'b0, 1'b0, 1'b0, 1'b1};
        tab_b[5] = '{1'b0, 8'd10,  1'b0, 1'b0, 1'b0, 1'b0};

        rstt   = 1'b1;
        udd    = 1'b1;
        rstt_s = 1'b1;
        udd_s  = 1'b0;
        #1;
        rstt   = 1'b0;
        rstt_s = 1'b0;
        #2;
        chk("rst.contt", 32'(contt), 32'd0);
        chk("rst.min",   32'(min_o), 32'd1);
        chk("rst.max",   32'(max_o), 32'd0);
        chk("rst.wrap",  32'(wrap_o), 32'd0);
        chk("rst.dir",   32'(dir_o), 32'd0);
        // rising edge at t=5 occurs while reset is held
        #8;
        chk("rst_hold.contt", 32'(contt), 32'd0);
        rstt = 1'b1;

        for (int i = 0; i < 8; i++) begin
            udd = tab_a[i].udd;
            tick();
            chk_all($sformatf("tabA[%0d]", i), tab_a[i]);
        end

        udd = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("up5.contt", 32'(contt), 32'd5);
        #2;
        rstt = 1'b0;
        #1;
        chk("async_rst.contt", 32'(contt), 32'd0);
        chk("async_rst.min",   32'(min_o), 32'd1);
        chk("async_rst.dir",   32'(dir_o), 32'd0);
        tick();
        chk("rst_edge.contt", 32'(contt), 32'd0);
        rstt = 1'b1;
        udd  = 1'b1;
        tick();
        tick();
        chk("after_rst.contt", 32'(contt), 32'd2);
        chk("after_rst.dir",   32'(dir_o), 32'd1);

        for (int i = 0; i < 8; i++) tick();
        chk("up10.contt", 32'(contt), 32'd10);
        for (int i = 0; i < 6; i++) begin
            udd = tab_b[i].udd;
            tick();
            chk_all($sformatf("tabB[%0d]", i), tab_b[i]);
        end

        rstt_s = 1'b1;
        udd_s  = 1'b0;
        tick();
        chk("sat_low.contt", 32'(contt_s), 32'd0);
        chk("sat_low.min",   32'(min_s), 32'd1);
        tick();
        chk("sat_low2.contt", 32'(contt_s), 32'd0);
        udd_s = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        chk("sat_top.contt", 32'(contt_s), 32'd255);
        chk("sat_top.max",   32'(max_s), 32'd1);
        tick();
        chk("sat_hold.contt", 32'(contt_s), 32'd255);
        chk("sat_hold.dir",   32'(dir_s), 32'd1);
        udd_s = 1'b0;
        tick();
        chk("sat_down.contt", 32'(contt_s), 32'd254);
        chk("sat_down.dir",   32'(dir_s), 32'd0);
        chk("sat_wrap_never", 32'(sat_wrap_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
